// File: rtl/div_issue_arb.sv
// div_issue_arb: round-robin front end that lets two requesters share one
// iterative divider, issues one op at a time and holds the result until the
// writeback port acknowledges it.
// Optional feature macro: DIV_ZERO_FASTPATH_EN -- when defined, a zero divisor
// is resolved locally (all ones for divide, dividend for remainder) without
// occupying the divider.

`ifndef M_WIDTH
`define M_WIDTH 64
`endif
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 5
`endif
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 7
`endif

module div_issue_arb #(
    parameter int LG_W = 5
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [`M_WIDTH-1:0]        req0_a,
    input  logic [`M_WIDTH-1:0]        req0_b,
    input  logic [`LG_ROB_ENTRIES-1:0] req0_rob_ptr,
    input  logic [`LG_PRF_ENTRIES-1:0] req0_prf_ptr,
    input  logic                       req0_is_signed,
    input  logic                       req0_is_rem,

    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [`M_WIDTH-1:0]        req1_a,
    input  logic [`M_WIDTH-1:0]        req1_b,
    input  logic [`LG_ROB_ENTRIES-1:0] req1_rob_ptr,
    input  logic [`LG_PRF_ENTRIES-1:0] req1_prf_ptr,
    input  logic                       req1_is_signed,
    input  logic                       req1_is_rem,

    output logic                       div_start,
    output logic [`M_WIDTH-1:0]        div_a,
    output logic [`M_WIDTH-1:0]        div_b,
    output logic [`LG_ROB_ENTRIES-1:0] div_rob_ptr,
    output logic [`LG_PRF_ENTRIES-1:0] div_prf_ptr,
    output logic                       div_is_signed,
    output logic                       div_is_rem,

    input  logic                       div_complete,
    input  logic [`M_WIDTH-1:0]        div_y,
    input  logic [`LG_ROB_ENTRIES-1:0] div_rob_ptr_out,
    input  logic [`LG_PRF_ENTRIES-1:0] div_prf_ptr_out,

    input  logic                       flush,

    output logic                       wb_valid,
    input  logic                       wb_ack,
    output logic [`M_WIDTH-1:0]        wb_data,
    output logic [`LG_ROB_ENTRIES-1:0] wb_rob_ptr,
    output logic [`LG_PRF_ENTRIES-1:0] wb_prf_ptr,
    output logic                       wb_src
);

    localparam int W  = 1 << LG_W;
    localparam int MW = `M_WIDTH;
    localparam int RW = `LG_ROB_ENTRIES;
    localparam int PW = `LG_PRF_ENTRIES;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BUSY  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t state_reg, state_next;

    // Requester fields gathered into arrays so selection is a simple index.
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [W-1:0]  req_a      [2];
    logic [W-1:0]  req_b      [2];
    logic [RW-1:0] req_rob    [2];
    logic [PW-1:0] req_prf    [2];
    logic [1:0]    req_signed;
    logic [1:0]    req_rem;

    assign req_valid  = {req1_valid, req0_valid};
    assign req_a[0]   = req0_a[W-1:0];
    assign req_a[1]   = req1_a[W-1:0];
    assign req_b[0]   = req0_b[W-1:0];
    assign req_b[1]   = req1_b[W-1:0];
    assign req_rob[0] = req0_rob_ptr;
    assign req_rob[1] = req1_rob_ptr;
    assign req_prf[0] = req0_prf_ptr;
    assign req_prf[1] = req1_prf_ptr;
    assign req_signed = {req1_is_signed, req0_is_signed};
    assign req_rem    = {req1_is_rem, req0_is_rem};

    // Latched op and result state.
    logic          last_grant_reg;
    logic          src_reg;
    logic [W-1:0]  op_a_reg;
    logic [W-1:0]  op_b_reg;
    logic [RW-1:0] op_rob_reg;
    logic [PW-1:0] op_prf_reg;
    logic          op_signed_reg;
    logic          op_rem_reg;
    logic [MW-1:0] wb_data_reg;
    logic [RW-1:0] wb_rob_reg;
    logic [PW-1:0] wb_prf_reg;

    logic          grant_any;
    logic          grant_idx;
    logic          accept;
    logic          capture;
    logic          zero_fast;
    logic [W-1:0]  fast_result;

    // Round-robin grant: a lone requester always wins, a tie goes to the one
    // that did not win last time.
    always_comb begin
        grant_any = |req_valid;
        grant_idx = req_valid[1] & ~req_valid[0];
        if (&req_valid) begin
            grant_idx = ~last_grant_reg;
        end
    end

    // Acceptance only from IDLE, never while flushing or in reset.
    assign accept = (state_reg == IDLE) && !flush && !reset && grant_any;

    // Each requester sees ready only when it is the granted one.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_idx == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

`ifdef DIV_ZERO_FASTPATH_EN
    assign zero_fast = (req_b[grant_idx] == '0);
`else
    assign zero_fast = 1'b0;
`endif

    // Zero-divisor result: all ones for divide, dividend for remainder.
    assign fast_result = req_rem[grant_idx] ? req_a[grant_idx] : {W{1'b1}};

    // A flush in the completion cycle drops the result, so no capture then.
    assign capture = (state_reg == BUSY) && div_complete && !flush;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = zero_fast ? HOLD : ISSUE;
                end
            end
            ISSUE: begin
                state_next = flush ? IDLE : BUSY;
            end
            BUSY: begin
                // If the divider finishes in the flush cycle there is nothing
                // left to drain, so return straight to IDLE.
                if (flush) begin
                    state_next = div_complete ? IDLE : DRAIN;
                end else if (div_complete) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (flush || wb_ack) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (div_complete) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Op latch, round-robin history and writeback result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
            src_reg        <= 1'b0;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            op_rob_reg     <= '0;
            op_prf_reg     <= '0;
            op_signed_reg  <= 1'b0;
            op_rem_reg     <= 1'b0;
            wb_data_reg    <= '0;
            wb_rob_reg     <= '0;
            wb_prf_reg     <= '0;
        end else begin
            if (accept) begin
                last_grant_reg <= grant_idx;
                src_reg        <= grant_idx;
                op_a_reg       <= req_a[grant_idx];
                op_b_reg       <= req_b[grant_idx];
                op_rob_reg     <= req_rob[grant_idx];
                op_prf_reg     <= req_prf[grant_idx];
                op_signed_reg  <= req_signed[grant_idx];
                op_rem_reg     <= req_rem[grant_idx];
                if (zero_fast) begin
                    wb_data_reg <= MW'(fast_result);
                    wb_rob_reg  <= req_rob[grant_idx];
                    wb_prf_reg  <= req_prf[grant_idx];
                end
            end
            if (capture) begin
                wb_data_reg <= MW'(div_y[W-1:0]);
                wb_rob_reg  <= div_rob_ptr_out;
                wb_prf_reg  <= div_prf_ptr_out;
            end
        end
    end

    // Divider drive: start only in ISSUE, suppressed by flush or reset.
    assign div_start     = (state_reg == ISSUE) && !flush && !reset;
    assign div_a         = MW'(op_a_reg);
    assign div_b         = MW'(op_b_reg);
    assign div_rob_ptr   = op_rob_reg;
    assign div_prf_ptr   = op_prf_reg;
    assign div_is_signed = op_signed_reg;
    assign div_is_rem    = op_rem_reg;

    // Writeback port.
    assign wb_valid   = (state_reg == HOLD) && !reset;
    assign wb_data    = wb_data_reg;
    assign wb_rob_ptr = wb_rob_reg;
    assign wb_prf_ptr = wb_prf_reg;
    assign wb_src     = src_reg;

    // Operand bits above W are ignored by design.
    generate
        if (W < MW) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^{req0_a[MW-1:W], req0_b[MW-1:W],
                                 req1_a[MW-1:W], req1_b[MW-1:W],
                                 div_y[MW-1:W]};
        end
    endgenerate

endmodule

// File: tb/tb_div_issue_arb.sv
// tb_div_issue_arb: directed bench for div_issue_arb with a 34-cycle
// divider model and a scoreboard of expected writebacks.
// Honours DIV_ZERO_FASTPATH_EN for the zero-divisor step.

`ifndef M_WIDTH
`define M_WIDTH 64
`endif
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 5
`endif
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 7
`endif

module tb_div_issue_arb;

    localparam int MW = `M_WIDTH;
    localparam int RW = `LG_ROB_ENTRIES;
    localparam int PW = `LG_PRF_ENTRIES;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [MW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [RW-1:0] req0_rob_ptr, req1_rob_ptr;
    logic [PW-1:0] req0_prf_ptr, req1_prf_ptr;
    logic          req0_is_signed, req0_is_rem, req1_is_signed, req1_is_rem;
    logic          div_start;
    logic [MW-1:0] div_a, div_b;
    logic [RW-1:0] div_rob_ptr;
    logic [PW-1:0] div_prf_ptr;
    logic          div_is_signed, div_is_rem;
    logic          div_complete;
    logic [MW-1:0] div_y;
    logic [RW-1:0] div_rob_ptr_out;
    logic [PW-1:0] div_prf_ptr_out;
    logic          flush;
    logic          wb_valid, wb_ack;
    logic [MW-1:0] wb_data;
    logic [RW-1:0] wb_rob_ptr;
    logic [PW-1:0] wb_prf_ptr;
    logic          wb_src;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    div_issue_arb #(.LG_W(5)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req0_rob_ptr(req0_rob_ptr), .req0_prf_ptr(req0_prf_ptr),
        .req0_is_signed(req0_is_signed), .req0_is_rem(req0_is_rem),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b),
        .req1_rob_ptr(req1_rob_ptr), .req1_prf_ptr(req1_prf_ptr),
        .req1_is_signed(req1_is_signed), .req1_is_rem(req1_is_rem),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_rob_ptr(div_rob_ptr), .div_prf_ptr(div_prf_ptr),
        .div_is_signed(div_is_signed), .div_is_rem(div_is_rem),
        .div_complete(div_complete), .div_y(div_y),
        .div_rob_ptr_out(div_rob_ptr_out), .div_prf_ptr_out(div_prf_ptr_out),
        .flush(flush),
        .wb_valid(wb_valid), .wb_ack(wb_ack), .wb_data(wb_data),
        .wb_rob_ptr(wb_rob_ptr), .wb_prf_ptr(wb_prf_ptr), .wb_src(wb_src)
    );

    // Reference 32-bit divide with RISC-V corner cases.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sg, input logic rm);
        if (b == 32'd0) return rm ? a : 32'hFFFF_FFFF;
        if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'd0 : a;
            return rm ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return rm ? (a % b) : (a / b);
    endfunction

    // Divider model: complete 34 cycles after the start cycle; upper result
    // bits carry junk so the DUT's zero-extension is exercised.
    logic          dv_busy = 1'b0;
    int            dv_cnt = 0;
    logic [31:0]   dv_a, dv_b;
    logic          dv_sg, dv_rm;
    logic [RW-1:0] dv_rob;
    logic [PW-1:0] dv_prf;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (div_start) start_cnt <= start_cnt + 1;
        if (reset) begin
            dv_busy <= 1'b0;
            dv_cnt  <= 0;
        end else if (div_start) begin
            dv_busy <= 1'b1;
            dv_cnt  <= 0;
            dv_a    <= div_a[31:0];
            dv_b    <= div_b[31:0];
            dv_sg   <= div_is_signed;
            dv_rm   <= div_is_rem;
            dv_rob  <= div_rob_ptr;
            dv_prf  <= div_prf_ptr;
        end else if (dv_busy) begin
            if (dv_cnt == 33) dv_busy <= 1'b0;
            dv_cnt <= dv_cnt + 1;
        end
    end

    assign div_complete    = dv_busy && (dv_cnt == 33);
    assign div_y           = {{(MW-32){1'b1}}, ref_div(dv_a, dv_b, dv_sg, dv_rm)};
    assign div_rob_ptr_out = dv_rob;
    assign div_prf_ptr_out = dv_prf;

    typedef struct {
        logic [MW-1:0] data;
        logic [RW-1:0] rob;
        logic [PW-1:0] prf;
        logic          src;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic sel, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic sg, input logic rm, input logic [RW-1:0] rob, input logic [PW-1:0] prf);
        if (sel) begin
            req1_valid = v; req1_a = MW'(a); req1_b = MW'(b);
            req1_is_signed = sg; req1_is_rem = rm; req1_rob_ptr = rob; req1_prf_ptr = prf;
        end else begin
            req0_valid = v; req0_a = MW'(a); req0_b = MW'(b);
            req0_is_signed = sg; req0_is_rem = rm; req0_rob_ptr = rob; req0_prf_ptr = prf;
        end
    endtask

    // Present an op, wait (bounded) for ready, optionally push its expected
    // writeback; returns with the DUT one cycle past the accept cycle.
    task automatic issue(input logic sel, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic rm, input logic [RW-1:0] rob,
                         input logic [PW-1:0] prf, input logic [MW-1:0] exp_data,
                         input logic push, output int acc_cyc);
        int n = 0;
        set_req(sel, 1'b1, a, b, sg, rm, rob, prf);
        #1;
        while (!(sel ? req1_ready : req0_ready) && n < 100) begin
            tick();
            n++;
        end
        check("accept_ready", MW'(sel ? req1_ready : req0_ready), 1);
        acc_cyc = cyc;
        if (push) exp_q.push_back('{exp_data, rob, prf, sel});
        tick();
        if (sel) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    // Wait (bounded) for wb_valid, compare against the scoreboard, optionally
    // stall the ack for hold cycles, then acknowledge.
    task automatic wait_wb(input int acc, input int exp_lat, input int hold);
        int n = 0;
        exp_t e;
        while (!wb_valid && n < 200) begin
            tick();
            n++;
        end
        check("wb_seen", MW'(wb_valid), 1);
        check("scoreboard_nonempty", MW'(exp_q.size() > 0), 1);
        if (wb_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wb_latency", MW'(cyc - acc), MW'(exp_lat));
            check("wb_data", wb_data, e.data);
            check("wb_rob_ptr", MW'(wb_rob_ptr), MW'(e.rob));
            check("wb_prf_ptr", MW'(wb_prf_ptr), MW'(e.prf));
            check("wb_src", MW'(wb_src), MW'(e.src));
            for (int i = 0; i < hold; i++) begin
                tick();
                check("hold_valid", MW'(wb_valid), 1);
                check("hold_data", wb_data, e.data);
                check("hold_rob", MW'(wb_rob_ptr), MW'(e.rob));
                check("hold_ready", MW'({req1_ready, req0_ready}), 0);
            end
            wb_ack = 1'b1;
            tick();
            wb_ack = 1'b0;
            check("wb_drop_after_ack", MW'(wb_valid), 0);
        end
    endtask

    // Safety net against a hung run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, a1, s0, n;
        logic seen;

        reset = 1'b1; flush = 1'b0; wb_ack = 1'b0;
        set_req(1'b0, 1'b0, 0, 0, 0, 0, '0, '0);
        set_req(1'b1, 1'b0, 0, 0, 0, 0, '0, '0);

        // Reset state, with a requester valid during reset.
        req0_valid = 1'b1;
        tick(); tick(); tick();
        check("rst_req0_ready", MW'(req0_ready), 0);
        check("rst_div_start", MW'(div_start), 0);
        check("rst_wb_valid", MW'(wb_valid), 0);
        check("rst_div_a", div_a, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_ptrs", MW'({wb_rob_ptr, wb_prf_ptr}), 0);
        req0_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Basic unsigned divide 100/7 with latency check.
        issue(1'b0, 32'd100, 32'd7, 1'b0, 1'b0, RW'(3), PW'(17), MW'(14), 1'b1, a0);
        check("issue_start", MW'(div_start), 1);
        check("issue_a", div_a, MW'(100));
        check("issue_b", div_b, MW'(7));
        check("issue_ptrs", MW'({div_rob_ptr, div_prf_ptr}), MW'({RW'(3), PW'(17)}));
        tick();
        check("start_one_cycle", MW'(div_start), 0);
        wait_wb(a0, 36, 0);

        // Round robin: after reset req0 wins a tie, next tie goes to req1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(1'b0, 1'b1, 32'd50, 32'd5, 1'b0, 1'b0, RW'(1), PW'(2));
        set_req(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, RW'(21), PW'(99));
        #1;
        check("tie1_req0_ready", MW'(req0_ready), 1);
        check("tie1_req1_ready", MW'(req1_ready), 0);
        a0 = cyc;
        exp_q.push_back('{MW'(10), RW'(1), PW'(2), 1'b0});
        tick();
        req0_valid = 1'b0;
        wait_wb(a0, 36, 0);
        req0_valid = 1'b1;
        #1;
        check("tie2_req1_ready", MW'(req1_ready), 1);
        check("tie2_req0_ready", MW'(req0_ready), 0);
        a1 = cyc;
        exp_q.push_back('{MW'(32'hFFFF_FFFF), RW'(21), PW'(99), 1'b1});
        tick();
        // Both stay valid while the signed remainder is held without ack.
        set_req(1'b1, 1'b1, 32'd3, 32'd1, 1'b0, 1'b0, RW'(2), PW'(2));
        wait_wb(a1, 36, 10);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Flush while BUSY: drained result never written back.
        issue(1'b0, 32'd1000, 32'd10, 1'b0, 1'b0, RW'(4), PW'(5), MW'(100), 1'b0, a0);
        for (int i = 0; i < 5; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_req(1'b0, 1'b1, 32'd81, 32'd9, 1'b0, 1'b0, RW'(6), PW'(7));
        #1;
        seen = 1'b0;
        n = 0;
        while (!req0_ready && n < 100) begin
            if (wb_valid) seen = 1'b1;
            tick();
            n++;
        end
        check("drain_no_wb", MW'(seen), 0);
        check("drain_reaccept_cycle", MW'(cyc), MW'(a0 + 36));
        issue(1'b0, 32'd81, 32'd9, 1'b0, 1'b0, RW'(6), PW'(7), MW'(9), 1'b1, a1);
        wait_wb(a1, 36, 0);

        // Flush in ISSUE suppresses div_start; flush in IDLE blocks accept.
        s0 = start_cnt;
        issue(1'b1, 32'd20, 32'd4, 1'b0, 1'b0, RW'(9), PW'(10), MW'(5), 1'b0, a0);
        flush = 1'b1;
        #1;
        check("flush_issue_no_start", MW'(div_start), 0);
        tick();
        flush = 1'b0;
        check("flush_issue_start_cnt", MW'(start_cnt - s0), 0);
        req1_valid = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_idle_no_ready", MW'(req1_ready), 0);
        tick();
        flush = 1'b0;
        #1;
        check("idle_after_flush_ready", MW'(req1_ready), 1);

        // Flush and ack together in HOLD: result dropped.
        issue(1'b1, 32'd20, 32'd4, 1'b0, 1'b0, RW'(9), PW'(10), MW'(5), 1'b0, a0);
        n = 0;
        while (!wb_valid && n < 100) begin
            tick();
            n++;
        end
        check("hold_reached", MW'(wb_valid), 1);
        check("hold_data_20_4", wb_data, MW'(5));
        flush = 1'b1;
        wb_ack = 1'b1;
        tick();
        flush = 1'b0;
        wb_ack = 1'b0;
        check("flush_hold_drop", MW'(wb_valid), 0);

        // Zero divisor handling.
        s0 = start_cnt;
`ifdef DIV_ZERO_FASTPATH_EN
        issue(1'b0, 32'd9, 32'd0, 1'b0, 1'b0, RW'(11), PW'(12), MW'(32'hFFFF_FFFF), 1'b1, a0);
        wait_wb(a0, 1, 0);
        issue(1'b0, 32'd9, 32'd0, 1'b0, 1'b1, RW'(13), PW'(14), MW'(9), 1'b1, a0);
        wait_wb(a0, 1, 0);
        check("fastpath_no_start", MW'(start_cnt - s0), 0);
`else
        issue(1'b0, 32'd9, 32'd0, 1'b0, 1'b0, RW'(11), PW'(12), MW'(32'hFFFF_FFFF), 1'b1, a0);
        wait_wb(a0, 36, 0);
        issue(1'b0, 32'd9, 32'd0, 1'b0, 1'b1, RW'(13), PW'(14), MW'(9), 1'b1, a0);
        wait_wb(a0, 36, 0);
        check("zero_div_issued", MW'(start_cnt - s0), 2);
`endif

        check("scoreboard_empty", MW'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_issue_arb.md
DIV_ISSUE_ARB -- requirements
Module: div_issue_arb

Interface
REQ-001 Parameter LG_W, default 5, meaning: log2 of divider operand width W=1<<LG_W; SHALL match the attached divider instance.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid/req1_valid  input  1 each  requester has a divide op pending.
REQ-005 req0_ready/req1_ready  output  1 each  op accepted this cycle when valid&ready.
REQ-006 reqN_a, reqN_b  input  `M_WIDTH each  dividend and divisor; only bits [W-1:0] are used.
REQ-007 reqN_rob_ptr  input  `LG_ROB_ENTRIES; reqN_prf_ptr  input  `LG_PRF_ENTRIES; reqN_is_signed, reqN_is_rem  input  1 each.
REQ-008 div_start, div_a, div_b, div_rob_ptr, div_prf_ptr, div_is_signed, div_is_rem  output  widths as above  drive divider inputs.
REQ-009 div_complete  input  1; div_y  input  `M_WIDTH; div_rob_ptr_out  input  `LG_ROB_ENTRIES; div_prf_ptr_out  input  `LG_PRF_ENTRIES  divider result.
REQ-010 flush  input  1  kill any op held or in flight.
REQ-011 wb_valid  output  1; wb_ack  input  1; wb_data  output  `M_WIDTH; wb_rob_ptr  output  `LG_ROB_ENTRIES; wb_prf_ptr  output  `LG_PRF_ENTRIES; wb_src  output  1  (requester index).

Function
REQ-012 States: IDLE, ISSUE, BUSY, HOLD, DRAIN.
REQ-013 reqN_ready SHALL be 1 only in IDLE with flush=0, and only for the granted requester.
REQ-014 Grant: if one valid, grant it; if both, grant the one not granted last (round robin, last-grant register).
REQ-015 IDLE + accept: latch op fields and source index, go to ISSUE.
REQ-016 ISSUE: div_start=1 for exactly that one cycle with latched fields on div_* outputs, go to BUSY; div_start SHALL be 0 in every other state.
REQ-017 BUSY: on div_complete, capture wb_data[W-1:0]=div_y[W-1:0], upper bits 0, plus returned rob/prf ptrs; go to HOLD.
REQ-018 HOLD: wb_valid=1, outputs stable until wb_ack; on wb_ack go to IDLE (new accept earliest next cycle).
REQ-019 Latency, W=32: accept cycle A, div_start at A+1, div_complete at A+35, wb_valid first at A+36.
REQ-020 Flush in ISSUE: no div_start, go to IDLE. In BUSY: go to DRAIN. In HOLD: wb_valid deasserted next cycle, go to IDLE. In IDLE: no accept that cycle.
REQ-021 DRAIN: wait for div_complete, discard result, go to IDLE; wb_valid=0; further flushes ignored.
REQ-022 div_complete outside BUSY/DRAIN SHALL be ignored.
REQ-023 flush and wb_ack in the same HOLD cycle: flush wins; result is dropped and not counted as written back.

Reset
REQ-024 reset SHALL force IDLE, last-grant=1 (req0 wins first tie), all latched fields 0.
REQ-025 Reset-state outputs: reqN_ready=0 during reset cycle, div_start=0, wb_valid=0, all data/pointer outputs 0.
REQ-026 Reset mid-operation SHALL abandon any op without writeback; divider shares the same reset.

Configuration
REQ-027 Macro DIV_ZERO_FASTPATH_EN: when defined, an accepted op with b[W-1:0]==0 SHALL skip ISSUE/BUSY and enter HOLD the next cycle with wb_data[W-1:0]=all ones (divide) or a[W-1:0] (remainder), upper bits 0.
REQ-028 Without DIV_ZERO_FASTPATH_EN, zero divisors SHALL be issued to the divider like any other op, result passed through unmodified.

Verification
REQ-029 req0 a=100,b=7 unsigned div at cycle A -> div_start at A+1, wb_valid at A+36, wb_data=14, wb_src=0.
REQ-030 Both valid in same IDLE cycle after reset -> req0 granted; both valid again after writeback -> req1 granted.
REQ-031 req1 signed rem a=-7,b=2 -> wb_data[31:0]=0xFFFFFFFF (-1), rob/prf ptrs echoed.
REQ-032 flush 5 cycles after div_start -> DRAIN, div_complete discarded, wb_valid never 1, next req accepted after return to IDLE.
REQ-033 With DIV_ZERO_FASTPATH_EN, a=9,b=0 div -> wb_valid at A+1, wb_data=0xFFFFFFFF, div_start never 1; rem -> wb_data=9.
REQ-034 wb_ack held 0 for 10 cycles in HOLD -> wb outputs stable, both reqN_ready=0 throughout.
